// File: rtl/hcx_pkg.sv
// hcx_pkg: shared definitions for the HC operand stack and its instruction decoder.
//   - hcx_op_e  : 3-bit stack operation codes as they appear on the op port
//   - hcx_act_e : internal per-level data-path action chosen by the control logic
//   - default WIDTH / DEPTH of the classic A/B/C stack
package hcx_pkg;

  localparam int HCX_WIDTH_DEF = 8;
  localparam int HCX_DEPTH_DEF = 3;

  typedef enum logic [2:0] {
    HCX_OP_NOP     = 3'd0,
    HCX_OP_PUSH    = 3'd1,
    HCX_OP_POP     = 3'd2,
    HCX_OP_REPLACE = 3'd3,
    HCX_OP_DUP     = 3'd4,
    HCX_OP_SWAP    = 3'd5,
    HCX_OP_ROT     = 3'd6,
    HCX_OP_CLEAR   = 3'd7
  } hcx_op_e;

  // Action applied uniformly to every level; legality is already resolved.
  typedef enum logic [2:0] {
    HCX_ACT_HOLD = 3'd0,
    HCX_ACT_PUSH = 3'd1,
    HCX_ACT_POP  = 3'd2,
    HCX_ACT_REP  = 3'd3,
    HCX_ACT_SWAP = 3'd4,
    HCX_ACT_ROT  = 3'd5,
    HCX_ACT_CLR  = 3'd6
  } hcx_act_e;

endpackage

// File: rtl/hcx_operand_stack.sv
// hcx_operand_stack: parametrised register operand stack (level 0 = A = top).
// Ports:
//   clk         clock, all state updates on rising edge
//   nReset      synchronous active-low reset
//   op          stack operation (hcx_op_e), accepted every cycle
//   din         data for PUSH / REPLACE
//   err_clr     clears sticky ovf / unf (a same-cycle new error wins)
//   peek_idx    level index for peek_out
//   stackA_out  level 0, stackB_out level 1, stackC_out level 2 (registered)
//   peek_out    level[peek_idx], 0 when peek_idx >= DEPTH (combinational)
//   count       number of valid levels; empty / full decoded from it
//   ovf / unf   sticky overflow / underflow flags
module hcx_operand_stack
  import hcx_pkg::*;
#(
  parameter int WIDTH = HCX_WIDTH_DEF,
  parameter int DEPTH = HCX_DEPTH_DEF,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         din,
  input  logic                     err_clr,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]         stackA_out,
  output logic [WIDTH-1:0]         stackB_out,
  output logic [WIDTH-1:0]         stackC_out,
  output logic [WIDTH-1:0]         peek_out,
  output logic [CNTW-1:0]          count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  if (DEPTH < 3 || DEPTH > 16) begin : g_bad_depth
    $fatal(1, "hcx_operand_stack: DEPTH must be 3..16");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "hcx_operand_stack: WIDTH must be 1..32");
  end

  logic [DEPTH*WIDTH-1:0] levels_q, levels_d;
  logic [CNTW-1:0]        count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic [WIDTH-1:0] lvl_s [DEPTH];
  logic [WIDTH-1:0] push_val_s;
  logic [WIDTH-1:0] peek_s;
  hcx_act_e         act_s;
  hcx_op_e          op_s;
  logic             empty_s, full_s;
  logic             ovf_set_s, unf_set_s;

  assign op_s    = hcx_op_e'(op);
  assign empty_s = (count_q == {CNTW{1'b0}});
  assign full_s  = (count_q == CNTW'(DEPTH));

  // Decode the op into a level action, next count and flag updates.
  always_comb begin
    act_s      = HCX_ACT_HOLD;
    push_val_s = din;
    count_d    = count_q;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    case (op_s)
      HCX_OP_NOP: begin
        act_s = HCX_ACT_HOLD;
      end
      HCX_OP_PUSH: begin
        act_s = HCX_ACT_PUSH;
        if (full_s) begin
          ovf_set_s = 1'b1;  // bottom level falls off, count saturates
        end else begin
          count_d = count_q + CNTW'(1);
        end
      end
      HCX_OP_POP: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          act_s   = HCX_ACT_POP;
          count_d = count_q - CNTW'(1);
        end
      end
      HCX_OP_REPLACE: begin
        act_s = HCX_ACT_REP;
        if (empty_s) begin
          count_d = CNTW'(1);  // writing the top of an empty stack makes it valid
        end else begin
          count_d = count_q;
        end
      end
      HCX_OP_DUP: begin
        push_val_s = lvl_s[0];
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          act_s = HCX_ACT_PUSH;
          if (full_s) begin
            ovf_set_s = 1'b1;
          end else begin
            count_d = count_q + CNTW'(1);
          end
        end
      end
      HCX_OP_SWAP: begin
        if (count_q < CNTW'(2)) begin
          unf_set_s = 1'b1;
        end else begin
          act_s = HCX_ACT_SWAP;
        end
      end
      HCX_OP_ROT: begin
        if (count_q < CNTW'(3)) begin
          unf_set_s = 1'b1;
        end else begin
          act_s = HCX_ACT_ROT;
        end
      end
      HCX_OP_CLEAR: begin
        act_s   = HCX_ACT_CLR;
        count_d = {CNTW{1'b0}};
      end
      default: begin
        act_s = HCX_ACT_HOLD;
      end
    endcase
    // A new error in the same cycle as err_clr leaves the flag set.
    ovf_d = ovf_set_s | (ovf_q & ~err_clr);
    unf_d = unf_set_s | (unf_q & ~err_clr);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_lvl
    logic [WIDTH-1:0] up_s;    // value shifted in on PUSH
    logic [WIDTH-1:0] dn_s;    // value shifted in on POP
    logic [WIDTH-1:0] rep_s;   // value after REPLACE
    logic [WIDTH-1:0] swap_s;  // value after SWAP
    logic [WIDTH-1:0] rot_s;   // value after ROT (A<=C, B<=A, C<=B)
    logic [WIDTH-1:0] nxt_s;

    assign lvl_s[i] = levels_q[i*WIDTH +: WIDTH];

    if (i == 0) begin : g_top
      assign up_s   = push_val_s;
      assign rep_s  = din;
      assign swap_s = lvl_s[1];
      assign rot_s  = lvl_s[2];
    end else begin : g_below
      assign up_s   = lvl_s[i-1];
      assign rep_s  = lvl_s[i];
      if (i == 1) begin : g_b
        assign swap_s = lvl_s[0];
        assign rot_s  = lvl_s[0];
      end else if (i == 2) begin : g_c
        assign swap_s = lvl_s[i];
        assign rot_s  = lvl_s[1];
      end else begin : g_rest
        assign swap_s = lvl_s[i];
        assign rot_s  = lvl_s[i];
      end
    end

    // Bottom level refills with zero so invalid levels stay cleared.
    if (i == DEPTH - 1) begin : g_bottom
      assign dn_s = {WIDTH{1'b0}};
    end else begin : g_mid
      assign dn_s = lvl_s[i+1];
    end

    // Per-level next-value mux.
    always_comb begin
      nxt_s = lvl_s[i];
      case (act_s)
        HCX_ACT_HOLD: nxt_s = lvl_s[i];
        HCX_ACT_PUSH: nxt_s = up_s;
        HCX_ACT_POP:  nxt_s = dn_s;
        HCX_ACT_REP:  nxt_s = rep_s;
        HCX_ACT_SWAP: nxt_s = swap_s;
        HCX_ACT_ROT:  nxt_s = rot_s;
        HCX_ACT_CLR:  nxt_s = {WIDTH{1'b0}};
        default:      nxt_s = lvl_s[i];
      endcase
    end

    assign levels_d[i*WIDTH +: WIDTH] = nxt_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      levels_q <= {(DEPTH*WIDTH){1'b0}};
      count_q  <= {CNTW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      levels_q <= levels_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Indexed peek; indices beyond the stack read as zero.
  always_comb begin
    peek_s = {WIDTH{1'b0}};
    if (int'(peek_idx) < DEPTH) begin
      peek_s = lvl_s[peek_idx];
    end else begin
      peek_s = {WIDTH{1'b0}};
    end
  end

  assign stackA_out = lvl_s[0];
  assign stackB_out = lvl_s[1];
  assign stackC_out = lvl_s[2];
  assign peek_out   = peek_s;
  assign count      = count_q;
  assign empty      = empty_s;
  assign full       = full_s;
  assign ovf        = ovf_q;
  assign unf        = unf_q;

endmodule
